// File: rtl/el2_lsu_dccm_stbuf.sv
// Committed-store buffer ahead of the DCCM write port: FIFO of split, ECC-protected
// stores drained when loads leave the RAM idle. Optional load/store forwarding hazard check under EL2_STBUF_FWD_EN.
module el2_lsu_dccm_stbuf #(
  parameter int DEPTH            = 4,
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int STARVE_MAX       = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [DCCM_BITS-1:0]        st_addr_lo,
  input  logic [DCCM_BITS-1:0]        st_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] st_data_hi,
  input  logic                        ld_req,
`ifdef EL2_STBUF_FWD_EN
  input  logic [DCCM_BITS-1:0]        ld_addr_lo,
  input  logic [DCCM_BITS-1:0]        ld_addr_hi,
  output logic                        ld_conflict,
`endif
  output logic                        ld_stall,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic [DCCM_BITS-1:0]        addr_lo_q [DEPTH];
  logic [DCCM_BITS-1:0]        addr_hi_q [DEPTH];
  logic [DCCM_FDATA_WIDTH-1:0] data_lo_q [DEPTH];
  logic [DCCM_FDATA_WIDTH-1:0] data_hi_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic full;
  logic enq;
  logic deq;
  logic force_drain;
  logic conflict;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == CNT_W'(0));
  assign st_ready    = ~full;
  assign enq         = st_valid & ~full;
  assign force_drain = (starve_cnt == STV_W'(STARVE_MAX));

`ifdef EL2_STBUF_FWD_EN
  // Word-granular match of the load against every occupied entry.
  logic             hit;
  logic [PTR_W-1:0] off;
  logic             unused_ld_addr_bits;

  assign unused_ld_addr_bits = ^{ld_addr_lo[1:0], ld_addr_hi[1:0]};

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (CNT_W'(off) < count) begin
        if ((addr_lo_q[i][DCCM_BITS-1:2] == ld_addr_lo[DCCM_BITS-1:2]) ||
            (addr_lo_q[i][DCCM_BITS-1:2] == ld_addr_hi[DCCM_BITS-1:2]) ||
            (addr_hi_q[i][DCCM_BITS-1:2] == ld_addr_lo[DCCM_BITS-1:2]) ||
            (addr_hi_q[i][DCCM_BITS-1:2] == ld_addr_hi[DCCM_BITS-1:2]))
          hit = 1'b1;
      end
    end
  end

  assign conflict    = ld_req & hit;
  assign ld_conflict = conflict;
`else
  assign conflict = 1'b0;
`endif

  assign dccm_wren = ~empty & (~ld_req | force_drain | conflict);
  assign ld_stall  = ld_req & ~empty & (force_drain | conflict);
  assign deq       = dccm_wren;

  // Head entry is always presented; storage resets to zero so outputs are never X.
  assign dccm_wr_addr_lo = addr_lo_q[rd_ptr];
  assign dccm_wr_addr_hi = addr_hi_q[rd_ptr];
  assign dccm_wr_data_lo = data_lo_q[rd_ptr];
  assign dccm_wr_data_hi = data_hi_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_lo_q[i] <= '0;
        addr_hi_q[i] <= '0;
        data_lo_q[i] <= '0;
        data_hi_q[i] <= '0;
      end
    end else if (enq) begin
      addr_lo_q[wr_ptr] <= st_addr_lo;
      addr_hi_q[wr_ptr] <= st_addr_hi;
      data_lo_q[wr_ptr] <= st_data_lo;
      data_hi_q[wr_ptr] <= st_data_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts cycles a pending drain loses to loads; saturates at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (empty || dccm_wren) begin
      starve_cnt <= '0;
    end else if (ld_req && !force_drain && !conflict) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

endmodule

// File: tb/tb_el2_lsu_dccm_stbuf.sv
// Directed, table-driven bench for el2_lsu_dccm_stbuf (default parameters).
module tb_el2_lsu_dccm_stbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] st_addr_lo, st_addr_hi;
  logic [38:0] st_data_lo, st_data_hi;
  logic        ld_req;
  logic        ld_stall;
  logic        dccm_wren;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic        empty;
`ifdef EL2_STBUF_FWD_EN
  logic [15:0] ld_addr_lo, ld_addr_hi;
  logic        ld_conflict;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  el2_lsu_dccm_stbuf dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr_lo(st_addr_lo), .st_addr_hi(st_addr_hi),
    .st_data_lo(st_data_lo), .st_data_hi(st_data_hi),
    .ld_req(ld_req),
`ifdef EL2_STBUF_FWD_EN
    .ld_addr_lo(ld_addr_lo), .ld_addr_hi(ld_addr_hi), .ld_conflict(ld_conflict),
`endif
    .ld_stall(ld_stall), .dccm_wren(dccm_wren),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .empty(empty)
  );

  typedef struct {
    logic        sv;
    logic [15:0] alo, ahi;
    logic [38:0] dlo, dhi;
    logic        ld;
    logic [3:0]  e_st;   // {st_ready, empty, dccm_wren, ld_stall}
    logic        chk;
    logic [15:0] e_alo, e_ahi;
    logic [38:0] e_dlo, e_dhi;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [15:0] alo, input logic [15:0] ahi,
                     input logic [38:0] dlo, input logic [38:0] dhi, input logic ld,
                     input logic [3:0] e_st, input logic chk,
                     input logic [15:0] e_alo, input logic [15:0] e_ahi,
                     input logic [38:0] e_dlo, input logic [38:0] e_dhi);
    vec_t v;
    v.sv = sv; v.alo = alo; v.ahi = ahi; v.dlo = dlo; v.dhi = dhi; v.ld = ld;
    v.e_st = e_st; v.chk = chk;
    v.e_alo = e_alo; v.e_ahi = e_ahi; v.e_dlo = e_dlo; v.e_dhi = e_dhi;
    vecs.push_back(v);
  endtask

  task automatic check_st(input string nm, input logic [3:0] want);
    logic [3:0] got;
    got = {st_ready, empty, dccm_wren, ld_stall};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: {rdy,empty,wren,stall} got %b want %b", nm, got, want);
    end
  endtask

  task automatic check_data(input string nm, input logic [15:0] alo, input logic [15:0] ahi,
                            input logic [38:0] dlo, input logic [38:0] dhi);
    n_cmp++;
    if (dccm_wr_addr_lo !== alo || dccm_wr_addr_hi !== ahi ||
        dccm_wr_data_lo !== dlo || dccm_wr_data_hi !== dhi) begin
      n_bad++;
      $display("FAIL %s: wr got %h/%h/%h/%h want %h/%h/%h/%h", nm,
               dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
               alo, ahi, dlo, dhi);
    end
  endtask

  task automatic drive(input logic sv, input logic [15:0] a, input logic [38:0] d, input logic ld);
    st_valid = sv; st_addr_lo = a; st_addr_hi = a; st_data_lo = d; st_data_hi = d; ld_req = ld;
  endtask

  localparam logic [38:0] D1 = 39'h1_2345_6789;

  initial begin
    // Single store, no loads: visible next cycle, gone the cycle after.
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1100, 1'b1, 16'h0, 16'h0, 39'h0, 39'h0);
    add(1'b1, 16'h0010, 16'h0010, D1, D1, 1'b0, 4'b1100, 1'b1, 16'h0, 16'h0, 39'h0, 39'h0);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1010, 1'b1, 16'h0010, 16'h0010, D1, D1);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1100, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    // Fill under continuous loads; 5th store held off; forced drain after 7 blocked cycles.
    for (int i = 0; i < 4; i++)
      add(1'b1, 16'(16'h0020 + 4*i), 16'(16'h0020 + 4*i), 39'(39'h100 + i), 39'(39'h200 + i), 1'b1,
          (i == 0) ? 4'b1100 : 4'b1000, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    for (int i = 0; i < 4; i++)
      add(1'b1, 16'h0030, 16'h0030, 39'h104, 39'h204, 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    add(1'b1, 16'h0030, 16'h0030, 39'h104, 39'h204, 1'b1, 4'b0011, 1'b1, 16'h0020, 16'h0020, 39'h100, 39'h200);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b1, 4'b1000, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    for (int i = 1; i < 4; i++)
      add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1010, 1'b1,
          16'(16'h0020 + 4*i), 16'(16'h0020 + 4*i), 39'(39'h100 + i), 39'(39'h200 + i));
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1100, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    // Streaming enqueue+dequeue: occupancy stays 1, FIFO order preserved across pointer wraps.
    add(1'b1, 16'h0400, 16'h0400, 39'h3000, 39'h3000, 1'b0, 4'b1100, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    for (int i = 1; i <= 10; i++)
      add(1'b1, 16'(16'h0400 + 4*i), 16'(16'h0400 + 4*i), 39'(39'h3000 + i), 39'(39'h3000 + i), 1'b0,
          4'b1010, 1'b1, 16'(16'h0400 + 4*(i-1)), 16'(16'h0400 + 4*(i-1)),
          39'(39'h3000 + i - 1), 39'(39'h3000 + i - 1));
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1010, 1'b1, 16'h0428, 16'h0428, 39'h300A, 39'h300A);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1100, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);
    // Unaligned store: both halves leave together, untouched.
    add(1'b1, 16'h0FFC, 16'h1000, 39'h55_1234_5678, 39'h2A_8765_4321, 1'b0, 4'b1100, 1'b0,
        16'h0, 16'h0, 39'h0, 39'h0);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1010, 1'b1,
        16'h0FFC, 16'h1000, 39'h55_1234_5678, 39'h2A_8765_4321);
    add(1'b0, 16'h0, 16'h0, 39'h0, 39'h0, 1'b0, 4'b1100, 1'b0, 16'h0, 16'h0, 39'h0, 39'h0);

    rst = 1'b1;
    drive(1'b0, 16'h0, 39'h0, 1'b0);
`ifdef EL2_STBUF_FWD_EN
    ld_addr_lo = 16'h0; ld_addr_hi = 16'h0;
`endif
    #2;
    check_st("in_reset", 4'b1100);
    check_data("in_reset_data", 16'h0, 16'h0, 39'h0, 39'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      st_valid = vecs[i].sv;
      st_addr_lo = vecs[i].alo; st_addr_hi = vecs[i].ahi;
      st_data_lo = vecs[i].dlo; st_data_hi = vecs[i].dhi;
      ld_req = vecs[i].ld;
      @(negedge clk);
      check_st($sformatf("vec%0d_status", i), vecs[i].e_st);
      if (vecs[i].chk)
        check_data($sformatf("vec%0d_data", i), vecs[i].e_alo, vecs[i].e_ahi, vecs[i].e_dlo, vecs[i].e_dhi);
      @(posedge clk); #1;
    end

    // Asynchronous reset while draining with three entries pending.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h0600 + 4*i), 39'(39'h7000 + i), 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, 16'h0, 39'h0, 1'b0);
    @(negedge clk);
    check_st("pre_rst_drain", 4'b1010);
    check_data("pre_rst_data", 16'h0600, 16'h0600, 39'h7000, 39'h7000);
    #2 rst = 1'b1;
    #1;
    check_st("async_rst", 4'b1100);
    check_data("async_rst_data", 16'h0, 16'h0, 39'h0, 39'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_st($sformatf("post_rst%0d", i), 4'b1100);
      @(posedge clk); #1;
    end

`ifdef EL2_STBUF_FWD_EN
    // Dependent load on a pending store drains it first, then proceeds.
    drive(1'b1, 16'h0104, 39'h0AB, 1'b1);
    ld_addr_lo = 16'h0200; ld_addr_hi = 16'h0200;
    @(posedge clk); #1;
    drive(1'b0, 16'h0, 39'h0, 1'b1);
    ld_addr_lo = 16'h0106; ld_addr_hi = 16'h0106;
    @(negedge clk);
    check_st("fwd_hit", 4'b1011);
    n_cmp++;
    if (ld_conflict !== 1'b1) begin
      n_bad++; $display("FAIL fwd_conflict: got %b want 1", ld_conflict);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check_st("fwd_after", 4'b1100);
    n_cmp++;
    if (ld_conflict !== 1'b0) begin
      n_bad++; $display("FAIL fwd_conflict_clr: got %b want 0", ld_conflict);
    end
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
